// File: rtl/vgpr_wr_port_arbiter_if.sv
// Write-port bundle between the two VGPR writers, the register file write port
// and the issue-side pending-write lookup.
interface vgpr_wr_port_arbiter_if #(
  parameter int CNT_W = 2
);
  logic             valu_wr_valid;
  logic             valu_wr_ready;
  logic [9:0]       valu_wr_addr;
  logic [3:0]       valu_wr_en;
  logic [31:0]      valu_wr_data;

  logic             lsu_wr_valid;
  logic             lsu_wr_ready;
  logic [9:0]       lsu_wr_addr;
  logic [3:0]       lsu_wr_en;
  logic [31:0]      lsu_wr_data;

  logic [9:0]       wr0_addr;
  logic [3:0]       wr0_en;
  logic [31:0]      wr0_data;

  logic [9:0]       query_addr;
  logic             query_pending;
  logic [CNT_W-1:0] valu_cnt;
  logic [CNT_W-1:0] lsu_cnt;

  modport master (
    output valu_wr_valid, valu_wr_addr, valu_wr_en, valu_wr_data,
    output lsu_wr_valid, lsu_wr_addr, lsu_wr_en, lsu_wr_data,
    output query_addr,
    input  valu_wr_ready, lsu_wr_ready,
    input  wr0_addr, wr0_en, wr0_data,
    input  query_pending, valu_cnt, lsu_cnt
  );

  modport slave (
    input  valu_wr_valid, valu_wr_addr, valu_wr_en, valu_wr_data,
    input  lsu_wr_valid, lsu_wr_addr, lsu_wr_en, lsu_wr_data,
    input  query_addr,
    output valu_wr_ready, lsu_wr_ready,
    output wr0_addr, wr0_en, wr0_data,
    output query_pending, valu_cnt, lsu_cnt
  );
endinterface

// File: rtl/vgpr_wr_port_arbiter.sv
// Two in-order writer FIFOs (VALU, LSU) drained round-robin into the registered
// VGPR write port, with a pending-write lookup over queued and in-flight writes.
module vgpr_wr_port_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  vgpr_wr_port_arbiter_if.slave  bus
);
  localparam int PTR_W = CNT_W - 1;
  localparam int VALU  = 0;
  localparam int LSU   = 1;

  typedef enum logic {PREF_VALU = 1'b0, PREF_LSU = 1'b1} pref_e;

  typedef struct packed {
    logic [9:0]  addr;
    logic [3:0]  en;
    logic [31:0] data;
  } entry_t;

  entry_t           mem [2][FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr [2];
  logic [PTR_W-1:0] wr_ptr [2];
  logic [CNT_W-1:0] cnt [2];
  pref_e            rr_pref;

  entry_t           in_entry [2];
  logic             in_valid [2];
  logic             ready [2];
  logic             push [2];
  logic             grant [2];
  logic             not_empty [2];
  logic             queued_hit;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    in_entry[VALU] = '{addr: bus.valu_wr_addr, en: bus.valu_wr_en, data: bus.valu_wr_data};
    in_entry[LSU]  = '{addr: bus.lsu_wr_addr,  en: bus.lsu_wr_en,  data: bus.lsu_wr_data};
    in_valid[VALU] = bus.valu_wr_valid;
    in_valid[LSU]  = bus.lsu_wr_valid;
    for (int p = 0; p < 2; p++) begin
      ready[p]     = (cnt[p] != CNT_W'(FIFO_DEPTH));
      not_empty[p] = (cnt[p] != '0);
      // Zero-enable requests complete the handshake but are dropped here.
      push[p]      = in_valid[p] && ready[p] && (in_entry[p].en != 4'b0000);
    end
    grant[VALU] = not_empty[VALU] && (!not_empty[LSU] || rr_pref == PREF_VALU);
    grant[LSU]  = not_empty[LSU] && !grant[VALU];
  end

  always_comb begin
    logic [PTR_W-1:0] offset;
    queued_hit = 1'b0;
    offset     = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        // Slot i is live when its distance from the read pointer is below the count.
        offset = PTR_W'(i) - rd_ptr[p];
        if (({1'b0, offset} < cnt[p]) && (mem[p][i].addr == bus.query_addr))
          queued_hit = 1'b1;
      end
    end
  end

  // NOTE: storage carries no reset; the counts and pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++)
      if (push[p]) mem[p][wr_ptr[p]] <= in_entry[p];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        rd_ptr[p] <= '0;
        wr_ptr[p] <= '0;
        cnt[p]    <= '0;
      end
      rr_pref      <= PREF_VALU;
      bus.wr0_addr <= '0;
      bus.wr0_en   <= '0;
      bus.wr0_data <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (push[p]) wr_ptr[p] <= wr_ptr[p] + PTR_W'(1);
        if (grant[p]) rd_ptr[p] <= rd_ptr[p] + PTR_W'(1);
        if (push[p] && !grant[p])      cnt[p] <= cnt[p] + CNT_W'(1);
        else if (!push[p] && grant[p]) cnt[p] <= cnt[p] - CNT_W'(1);
      end

      if (grant[VALU]) begin
        rr_pref      <= PREF_LSU;
        bus.wr0_addr <= mem[VALU][rd_ptr[VALU]].addr;
        bus.wr0_en   <= mem[VALU][rd_ptr[VALU]].en;
        bus.wr0_data <= mem[VALU][rd_ptr[VALU]].data;
      end else if (grant[LSU]) begin
        rr_pref      <= PREF_VALU;
        bus.wr0_addr <= mem[LSU][rd_ptr[LSU]].addr;
        bus.wr0_en   <= mem[LSU][rd_ptr[LSU]].en;
        bus.wr0_data <= mem[LSU][rd_ptr[LSU]].data;
      end else begin
        bus.wr0_en <= 4'b0000;
      end
    end
  end

  assign bus.valu_wr_ready = ready[VALU];
  assign bus.lsu_wr_ready  = ready[LSU];
  assign bus.valu_cnt      = cnt[VALU];
  assign bus.lsu_cnt       = cnt[LSU];
  assign bus.query_pending = queued_hit ||
                             ((bus.wr0_en != 4'b0000) && (bus.wr0_addr == bus.query_addr));
endmodule

// File: doc/vgpr_wr_port_arbiter.md
# vgpr_wr_port_arbiter

Arbitrates the single write port of the 1024x32b vector register file between two writers: the VALU result path and the LSU load-return path. Each writer gets a small in-order FIFO with a valid/ready handshake. A round-robin arbiter drains the FIFOs into registered `wr0_*` outputs that drive the register file's write port directly. A pending-write lookup lets the issue logic see whether a destination VGPR still has a write in flight.

## Interface
Parameters:
- `FIFO_DEPTH`, 2: entries per writer FIFO; power of 2, at least 2.
- `CNT_W`, 2: count width, equal to clog2(FIFO_DEPTH)+1.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `valu_wr_valid`  in  1  VALU write request.
- `valu_wr_ready`  out  1  VALU FIFO can accept.
- `valu_wr_addr`  in  10  VGPR address.
- `valu_wr_en`  in  4  write enable (legacy width).
- `valu_wr_data`  in  32  write data.
- `lsu_wr_valid`, `lsu_wr_ready`, `lsu_wr_addr`, `lsu_wr_en`, `lsu_wr_data`: same directions, widths and meanings for the LSU writer.
- `wr0_addr`  out  10  register file write address.
- `wr0_en`  out  4  register file write enable; `4'b0000` means idle.
- `wr0_data`  out  32  register file write data.
- `query_addr`  in  10  address to check for pending writes.
- `query_pending`  out  1  a write to `query_addr` is queued or being driven on `wr0_*`.
- `valu_cnt`  out  CNT_W  VALU FIFO occupancy.
- `lsu_cnt`  out  CNT_W  LSU FIFO occupancy.

## Operation
- Handshake per writer:
  - `*_ready = (cnt != FIFO_DEPTH)`, computed from the registered count only. A full FIFO is not ready even in a cycle where it pops.
  - A transfer happens when valid and ready are both high at a clock edge.
  - `valid` may stay high across cycles. Each cycle in which valid and ready are both high is one separate transfer.
- Zero-enable requests: a transfer with `*_wr_en == 4'b0000` is accepted and discarded. It is not enqueued and the count does not change.
- Each FIFO stores {addr, en, data} and pops strictly in order.
- Arbitration, evaluated combinationally every cycle:
  - If exactly one FIFO is non-empty, that FIFO wins.
  - If both are non-empty, the port selected by `rr_pref` wins.
  - On every grant, `rr_pref` switches to the port that did not win.
  - If neither FIFO is non-empty, there is no grant.
- Output register, updated at each edge:
  - With a grant: the winner's head is popped and `wr0_addr/wr0_en/wr0_data` load that head.
  - Without a grant: `wr0_en` loads `4'b0000` and `wr0_addr/wr0_data` hold their values.
  - The register file treats any nonzero `wr0_en` bit as a full 32b write.
- Counts: an enqueue and a pop on the same FIFO in the same cycle leave the count unchanged; otherwise the count moves by +1 or −1. Pointers wrap modulo FIFO_DEPTH.
- `query_pending` is combinational. It is high if any valid entry in either FIFO has addr equal to `query_addr`, or if `wr0_en != 0` and `wr0_addr == query_addr`.
- Ordering guarantee: writes from the same port to the same address reach the register file in issue order. Relative order between the two ports follows arbitration only. The scheduler must not issue conflicting cross-port writes to one VGPR while `query_pending` is high for it.
- Reset values:
  - Both FIFOs empty, both counts 0, both readies 1.
  - `wr0_en = 0`, `wr0_addr = 0`, `wr0_data = 0`.
  - `rr_pref = VALU`.
  - `query_pending = 0`.
- Reset asserted mid-operation drops every queued write and the write currently on `wr0_*`. No write is issued in the cycle after the reset edge.

## Timing
- Request accepted at edge E → entry visible from E → granted at edge E+1 (no contention, other FIFO empty) → `wr0_*` valid during the cycle after E+1 → register file writes at edge E+2.
- Throughput: one register file write per cycle sustained. Each port gets at least one grant in every two cycles while it is non-empty.
- `*_ready` falls in the cycle after the edge at which the count reaches FIFO_DEPTH. It rises in the cycle after the edge at which a pop lowers the count.
- `query_pending` reflects a new entry from its enqueue edge onward. It stays high through the cycle in which `wr0_*` drives that write, and falls after the following edge, once the register file has written.

## Test plan
- Single VALU write, addr 10'h005, en 4'hF, data 32'hDEADBEEF, accepted at edge 1 → `wr0_*` carries exactly that write in the cycle after edge 2, then `wr0_en` returns to 0. `query_pending` with `query_addr = 5` is high from edge 1 through that cycle.
- Both ports stream 4 writes each, valid held high, starting out of reset → grants alternate VALU, LSU, VALU, … Eight consecutive `wr0_en != 0` cycles, per-port data in issue order.
- LSU holds valid high and VALU sends nothing; LSU stream of 3 writes with DEPTH=2 → `lsu_cnt` sequence 0,1,1,1,0. `lsu_wr_ready` never drops because the drain keeps pace.
- LSU FIFO fill: hold arbitration by keeping VALU always winning (rr blocked is impossible, so instead force `rst`-free contention by filling LSU 2 entries while VALU saturates) → LSU ready low when `lsu_cnt == 2`. A third LSU valid is not accepted until a pop, and no write is lost or duplicated.
- `*_wr_en = 0` request → handshake completes, count unchanged, no `wr0` write.
- Assert `rst` for one cycle with both FIFOs holding 2 entries → the next cycle shows counts 0, readies 1, `wr0_en = 0`, `query_pending = 0`, and none of the pre-reset data ever appears on `wr0_*`.
